// File: rtl/ucsbece152a_counter.sv
// Command sequencer for an up/down counter: accepts "move to target" commands and
// steers the counter's enable/dir until the goal count is reached (up, down, bounce).
module ucsbece152a_counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_target_i,
  input  logic [1:0]       cmd_mode_i,
  input  logic             pause_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             enable_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH:0]   moves_o
);

  typedef enum logic [1:0] {IDLE, LEG1, LEG2, DONE} state_t;

  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] start_q;
  logic [1:0]       mode_q;
  logic [WIDTH:0]   moves_q;

  logic [WIDTH-1:0] goal;
  logic             at_goal;
  logic             accept;
  logic             moving;

  // The second leg of a bounce returns to the count captured at accept.
  assign goal    = (state == LEG2) ? start_q : target_q;
  assign at_goal = (count_i == goal);
  assign accept  = cmd_valid_i && (state == IDLE);
  assign moving  = (state == LEG1) || (state == LEG2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      target_q <= '0;
      start_q  <= '0;
      mode_q   <= '0;
      moves_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        target_q <= cmd_target_i;
        start_q  <= count_i;
        mode_q   <= cmd_mode_i;
        moves_q  <= '0;
      end else if (enable_o) begin
        moves_q <= moves_q + 1'b1;
      end
    end
  end

  // Abort takes priority over goal detection in both legs.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = LEG1;
      LEG1: begin
        if (abort_i)      state_nxt = IDLE;
        else if (at_goal) state_nxt = (mode_q == MODE_BOUNCE) ? LEG2 : DONE;
      end
      LEG2: begin
        if (abort_i)      state_nxt = IDLE;
        else if (at_goal) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enable is gated combinationally so the counter never steps past the goal.
  always_comb begin
    cmd_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
    done_o      = (state == DONE);
    enable_o    = moving && !pause_i && !abort_i && !at_goal;
    dir_o       = (state == LEG2) || ((state == LEG1) && (mode_q == MODE_DOWN));
  end

  assign moves_o = moves_q;

endmodule

// File: tb/tb_ucsbece152a_counter_ctrl.sv
// Bench for ucsbece152a_counter_ctrl: a behavioural counter drives count_i, and each
// command is checked against step counts and latencies derived from the move rules.
module tb_ucsbece152a_counter_ctrl;

  localparam int W = 3;
  localparam int M = 1 << W;

  logic         clk = 0;
  logic         rst = 0;
  logic         cmd_valid = 0;
  logic         cmd_ready;
  logic [W-1:0] cmd_target = '0;
  logic [1:0]   cmd_mode = '0;
  logic         pause = 0;
  logic         abort = 0;
  logic [W-1:0] cnt = '0;
  logic         enable, dir, busy, done;
  logic [W:0]   moves;

  logic         load = 0;
  logic [W-1:0] load_val = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ucsbece152a_counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_target_i(cmd_target), .cmd_mode_i(cmd_mode),
    .pause_i(pause), .abort_i(abort),
    .count_i(cnt),
    .enable_o(enable), .dir_o(dir), .busy_o(busy), .done_o(done),
    .moves_o(moves)
  );

  // Behavioural stand-in for the controlled up/down counter.
  always @(posedge clk) begin
    if (load)        cnt <= load_val;
    else if (enable) cnt <= dir ? cnt - 1'b1 : cnt + 1'b1;
  end

  function automatic int mod_m(input int v);
    return ((v % M) + M) % M;
  endfunction

  task automatic load_counter(input int s);
    @(posedge clk); #1;
    load = 1; load_val = W'(s);
    @(posedge clk); #1;
    load = 0;
  endtask

  // Issues one command and follows it to ready, checking it against the move rules.
  task automatic run_cmd(input int s, input int t, input int m, input int p_start,
                         input int p_len, input bit hold, input string name);
    int n1, n2, exp_done, exp_final, en_cnt, dir_err, done_cnt, done_k, ready_k;
    bit done_seen, exp_dir;
    int mm;
    mm = (m == 3) ? 0 : m;
    n1 = (mm == 1) ? mod_m(s - t) : mod_m(t - s);
    n2 = (mm == 2) ? n1 : 0;
    exp_final = (mm == 2) ? s : t;
    exp_done = n1 + n2 + 2 + ((mm == 2) ? 1 : 0) + p_len;
    en_cnt = 0; dir_err = 0; done_cnt = 0; done_k = 0; ready_k = 0; done_seen = 0;

    load_counter(s);
    cmd_valid = 1; cmd_target = W'(t); cmd_mode = 2'(m);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt !== W'(s)) begin
      errors++;
      $display("FAIL %s accept: ready=%b busy=%b count=%0d, required ready=1 busy=0 count=%0d",
               name, cmd_ready, busy, cnt, s);
    end

    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      cmd_valid  = hold && !done_seen;
      cmd_target = W'($urandom);
      cmd_mode   = 2'($urandom);
      pause      = (p_len > 0) && (k >= p_start) && (k < p_start + p_len);
      @(negedge clk);
      if (enable) begin
        exp_dir = (mm == 1) || ((mm == 2) && (en_cnt >= n1));
        if (dir !== exp_dir) dir_err++;
        en_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
        done_seen = 1;
      end
      if (cmd_ready) begin
        ready_k = k;
        break;
      end
    end
    cmd_valid = 0; pause = 0;

    checks++;
    if (ready_k == 0) begin
      errors++;
      $display("FAIL %s timeout: ready never returned within 200 cycles", name);
    end
    checks++;
    if (moves !== (W+1)'(n1 + n2)) begin
      errors++;
      $display("FAIL %s moves: got %0d, required %0d", name, moves, n1 + n2);
    end
    checks++;
    if (en_cnt != n1 + n2) begin
      errors++;
      $display("FAIL %s enable_cycles: got %0d, required %0d", name, en_cnt, n1 + n2);
    end
    checks++;
    if (cnt !== W'(exp_final)) begin
      errors++;
      $display("FAIL %s final_count: got %0d, required %0d", name, cnt, exp_final);
    end
    checks++;
    if (done_cnt != 1 || done_k != exp_done) begin
      errors++;
      $display("FAIL %s done: %0d pulses at cycle %0d, required 1 pulse at cycle %0d",
               name, done_cnt, done_k, exp_done);
    end
    checks++;
    if (ready_k != exp_done + 1) begin
      errors++;
      $display("FAIL %s ready_cycle: got %0d, required %0d", name, ready_k, exp_done + 1);
    end
    checks++;
    if (dir_err != 0) begin
      errors++;
      $display("FAIL %s dir: %0d steps with wrong direction, required 0", name, dir_err);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || enable !== 1'b0 || dir !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || moves !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b en=%b dir=%b busy=%b done=%b moves=%0d, required 1 0 0 0 0 0",
               cmd_ready, enable, dir, busy, done, moves);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_directed();
    run_cmd(0, 5, 0, 0, 0, 0, "up5");
    run_cmd(0, 6, 1, 0, 0, 1, "down6_busy_valid");
    run_cmd(2, 4, 2, 0, 0, 0, "bounce2to4");
    run_cmd(0, 6, 0, 3, 3, 0, "pause3");
    run_cmd(4, 4, 0, 0, 0, 0, "zero_up");
    run_cmd(4, 4, 3, 0, 0, 0, "zero_mode11");
    run_cmd(3, 3, 2, 0, 0, 0, "zero_bounce");
    run_cmd(1, 6, 3, 0, 0, 0, "mode11_up");
  endtask

  task automatic test_wrap();
    run_cmd(6, 1, 0, 0, 0, 0, "wrap_up");
    run_cmd(1, 6, 1, 0, 0, 0, "wrap_down");
    run_cmd(5, 2, 2, 2, 2, 0, "wrap_bounce_pause");
  endtask

  // Starts up 0->7 and interrupts in cycle 4, when the count sits at 3.
  task automatic test_abort(input bit use_rst);
    string name;
    name = use_rst ? "rst_mid" : "abort";
    load_counter(0);
    cmd_valid = 1; cmd_target = W'(7); cmd_mode = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      cmd_valid = 0;
    end
    @(posedge clk); #1;
    if (use_rst) rst = 1;
    else begin
      abort = 1;
      pause = 1;
    end
    @(negedge clk);
    if (!use_rst) begin
      checks++;
      if (enable !== 1'b0 || cnt !== W'(3) || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_same_cycle: en=%b count=%0d busy=%b, required en=0 count=3 busy=1",
                 enable, cnt, busy);
      end
    end
    @(posedge clk); #1;
    rst = 0; abort = 0; pause = 0;
    @(negedge clk);
    if (use_rst) begin
      checks++;
      if (cmd_ready !== 1'b1 || enable !== 1'b0 || dir !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || moves !== '0) begin
        errors++;
        $display("FAIL %s: ready=%b en=%b dir=%b busy=%b done=%b moves=%0d, required 1 0 0 0 0 0",
                 name, cmd_ready, enable, dir, busy, done, moves);
      end
    end else begin
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || moves !== (W+1)'(3) ||
          cnt !== W'(3)) begin
        errors++;
        $display("FAIL %s_after: busy=%b ready=%b done=%b moves=%0d count=%0d, required 0 1 0 3 3",
                 name, busy, cmd_ready, done, moves, cnt);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || moves !== (W+1)'(3)) begin
        errors++;
        $display("FAIL %s_hold: done=%b moves=%0d, required done=0 moves=3", name, done, moves);
      end
    end
  endtask

  task automatic test_random();
    int s, t, m, n1, ps, pl;
    for (int i = 0; i < 25; i++) begin
      s = $urandom_range(0, M - 1);
      t = $urandom_range(0, M - 1);
      m = $urandom_range(0, 3);
      n1 = (m == 1) ? mod_m(s - t) : mod_m(t - s);
      ps = 0; pl = 0;
      if (n1 > 0 && $urandom_range(0, 1) == 1) begin
        ps = $urandom_range(1, n1);
        pl = $urandom_range(1, 3);
      end
      run_cmd(s, t, m, ps, pl, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(0, 3, 0, 0, 0, 0, "b2b_a");
    run_cmd(3, 1, 1, 0, 0, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_abort(0);
    test_abort(1);
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucsbece152a_counter_ctrl.md
# ucsbece152a_counter_ctrl

Command-driven sequencer for the up/down counter (`ucsbece152a_counter`). It accepts "move to target" commands over a valid/ready handshake. While a command runs, it drives the counter's `enable_i`/`dir_i` and watches `count_o` until the target is reached. It supports up, down and bounce (out-and-back) moves, plus pause and abort. It sits between a command source (FSM, switches, test bench) and one counter instance, on the same clock.

## Interface
- `WIDTH`, default 3: counter width; must equal the controlled counter's `WIDTH`.
- `clk`  in  1: system clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid_i`  in  1: command present.
- `cmd_ready_o`  out  1: controller idle and able to accept; a command is accepted on an edge where valid && ready.
- `cmd_target_i`  in  WIDTH: target count value.
- `cmd_mode_i`  in  2: 00 up, 01 down, 10 bounce (up to target, then down back to the start value), 11 reserved and treated as up.
- `pause_i`  in  1: level; freezes movement without leaving the current state.
- `abort_i`  in  1: terminates the running command; no done pulse.
- `count_i`  in  WIDTH: connected to the counter's `count_o`.
- `enable_o`  out  1: to the counter's `enable_i`.
- `dir_o`  out  1: to the counter's `dir_i`; 0 = increment, 1 = decrement.
- `busy_o`  out  1: state is not IDLE.
- `done_o`  out  1: one-cycle completion pulse.
- `moves_o`  out  WIDTH+1: number of counter steps issued for the current or last command.

## Operation
- States: IDLE, LEG1, LEG2, DONE. Reset → IDLE.
- Reset values: `cmd_ready_o`=1, `enable_o`=0, `dir_o`=0, `busy_o`=0, `done_o`=0, `moves_o`=0; internal target, start and mode registers = 0.
- IDLE
  - `cmd_ready_o`=1.
  - On accept: latch target, mode, and start = `count_i`; clear `moves_o`; go to LEG1.
  - `cmd_valid_i` is ignored in every other state.
- LEG1
  - `dir_o` = 1 only for down mode, else 0.
  - If `count_i` == target: go to LEG2 if mode is bounce, else go to DONE.
- LEG2 (bounce only)
  - `dir_o`=1; the goal is the latched start value.
  - If `count_i` == start: go to DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `enable_o` is combinational: (state is LEG1 or LEG2) && !`pause_i` && !`abort_i` && `count_i` != current goal. The counter therefore stops exactly on the goal with no overshoot.
- `moves_o` increments on every edge where `enable_o`=1. It is held through DONE/IDLE until the next accept. It cannot overflow, since the bounce maximum is 2·(2^WIDTH−1).
- Wrap-around
  - Up with target < start moves through 2^WIDTH−1 → 0.
  - Down with target > start moves through 0 → 2^WIDTH−1.
  - No shortest-path selection is made.
- Target equal to start: no moves; up/down completes via DONE. Bounce passes LEG1 and LEG2 with zero moves and still pulses `done_o`.
- `abort_i` in LEG1/LEG2: `enable_o` drops in the same cycle; next state IDLE; `done_o` stays 0; `moves_o` is held. Abort in IDLE/DONE has no effect.
- `pause_i` together with `abort_i`: abort wins.
- `rst` at any point returns to IDLE with reset values; the counter's own reset is separate.

## Timing
- Accept edge E0. Counter steps occur on edges E1..EN, where N = moves.
- Goal equality is seen in the cycle after EN; the state transitions at EN+1.
- `done_o` is high for the cycle after EN+1; `cmd_ready_o` returns after EN+2.
- An up/down command with N moves and no pause takes N+3 cycles from accept to ready.
- A bounce command adds one equality-detect cycle per leg: up-leg moves + down-leg moves + 4 cycles.
- Each paused cycle adds exactly one cycle of latency.
- `count_i` is assumed to change only on edges where `enable_o` was 1. Any other change (for example, an external counter reset) is simply re-evaluated against the goal each cycle.

## Test plan
- WIDTH=3, counter at 0; cmd up, target 5 → `enable_o` high 5 cycles; `count_i` 1..5; `done_o` pulses on cycle 7 after accept; `moves_o`=5; ready on cycle 8.
- Counter at 0; cmd down, target 6 → `dir_o`=1; count goes 7, 6; `moves_o`=2; a second `cmd_valid_i` issued while busy is ignored.
- Counter at 2; cmd bounce, target 4 → count 3, 4, 3, 2; `dir_o` 0 then 1; `moves_o`=4; one `done_o` pulse.
- Cmd up, target 6 from 0; `pause_i` for 3 cycles at count 2 → count holds at 2; `moves_o` holds; completion is delayed by exactly 3 cycles; final `moves_o`=6.
- Cmd up, target 7; `abort_i` at count 3 → `enable_o` drops the same cycle; count stays 3; no `done_o`; IDLE next cycle; `moves_o`=3. Repeat with `rst` mid-run → all outputs return to reset values.
- Counter at 4; cmd up, target 4 → zero moves; `done_o` on cycle 2 after accept; `moves_o`=0; mode 11 behaves as up.
